// File: rtl/mem_load_ext.sv
// Load-data extractor: selects a byte/half/word/dword field from an aligned memory
// word, sign- or zero-extends it, and flags misaligned accesses through one register stage.
module mem_load_ext #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [1:0]        in_size,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_adel,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] ext_res;
  logic              sbit;
  logic              misaligned;
  logic              in_accept;

  assign in_ready  = !out_valid || out_ready;
  assign in_accept = in_valid && in_ready;

  // Field is moved down to bit 0 first; the mask then splits kept bits from extension bits.
  always_comb begin
    shifted    = in_data >> {in_off, 3'b000};
    mask       = '1;
    sbit       = 1'b0;
    misaligned = 1'b0;
    case (in_size)
      2'd0: begin
        mask = DATA_W'(64'h0000_0000_0000_00FF);
        sbit = shifted[7];
      end
      2'd1: begin
        mask       = DATA_W'(64'h0000_0000_0000_FFFF);
        sbit       = shifted[15];
        misaligned = in_off[0];
      end
      2'd2: begin
        mask       = DATA_W'(64'h0000_0000_FFFF_FFFF);
        sbit       = shifted[31];
        misaligned = (in_off[1:0] != 2'b00);
      end
      default: begin
        mask       = '1;
        sbit       = shifted[DATA_W-1];
        misaligned = (DATA_W == 32) || (in_off != '0);
      end
    endcase
    ext_res = (shifted & mask) | ({DATA_W{in_sign & sbit}} & ~mask);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_adel  <= 1'b0;
    end else if (in_accept) begin
      out_valid <= 1'b1;
      out_data  <= misaligned ? '0 : ext_res;
      out_adel  <= misaligned;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (in_accept && misaligned && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_load_ext.sv
// Directed bench for mem_load_ext: vector table on a 32-bit instance, plus handshake,
// saturation (CNT_W=2), 64-bit extraction and asynchronous reset sequences.
module tb_mem_load_ext;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Instance A (32-bit, CNT_W=8) and C (32-bit, CNT_W=2) share data inputs.
  logic        a_valid, a_clr, a_ordy, a_iready, a_ovalid, a_adel;
  logic [31:0] d_data, a_odata;
  logic [1:0]  d_off, d_size;
  logic        d_sign;
  logic [7:0]  a_cnt;

  logic        c_valid, c_clr, c_iready, c_ovalid, c_adel;
  logic [31:0] c_odata;
  logic [1:0]  c_cnt;

  logic        b_valid, b_sign, b_iready, b_ovalid, b_adel;
  logic [63:0] b_data, b_odata;
  logic [2:0]  b_off;
  logic [1:0]  b_size;
  logic [7:0]  b_cnt;

  mem_load_ext #(.DATA_W(32), .CNT_W(8)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(a_valid), .in_ready(a_iready),
    .in_data(d_data), .in_off(d_off), .in_size(d_size), .in_sign(d_sign),
    .out_valid(a_ovalid), .out_ready(a_ordy), .out_data(a_odata), .out_adel(a_adel),
    .err_clr(a_clr), .err_cnt(a_cnt));

  mem_load_ext #(.DATA_W(32), .CNT_W(2)) u_c (
    .clk(clk), .resetn(resetn), .in_valid(c_valid), .in_ready(c_iready),
    .in_data(d_data), .in_off(d_off), .in_size(d_size), .in_sign(d_sign),
    .out_valid(c_ovalid), .out_ready(1'b1), .out_data(c_odata), .out_adel(c_adel),
    .err_clr(c_clr), .err_cnt(c_cnt));

  mem_load_ext #(.DATA_W(64), .CNT_W(8)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(b_valid), .in_ready(b_iready),
    .in_data(b_data), .in_off(b_off), .in_size(b_size), .in_sign(b_sign),
    .out_valid(b_ovalid), .out_ready(1'b1), .out_data(b_odata), .out_adel(b_adel),
    .err_clr(1'b0), .err_cnt(b_cnt));

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] exp_data;
    logic        exp_adel;
    logic [7:0]  exp_cnt;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h12345680, 2'd0, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0, 8'd0};
    vecs[1] = '{32'h12345680, 2'd2, 2'd1, 1'b0, 32'h00001234, 1'b0, 8'd0};
    vecs[2] = '{32'h80000000, 2'd2, 2'd1, 1'b1, 32'hFFFF8000, 1'b0, 8'd0};
    vecs[3] = '{32'h12345680, 2'd1, 2'd1, 1'b0, 32'h00000000, 1'b1, 8'd1};
    vecs[4] = '{32'h12345680, 2'd0, 2'd3, 1'b1, 32'h00000000, 1'b1, 8'd2};
    vecs[5] = '{32'h12345680, 2'd3, 2'd0, 1'b1, 32'h00000012, 1'b0, 8'd2};
    vecs[6] = '{32'hDEADBEEF, 2'd0, 2'd2, 1'b1, 32'hDEADBEEF, 1'b0, 8'd2};
    vecs[7] = '{32'h12345680, 2'd1, 2'd0, 1'b0, 32'h00000056, 1'b0, 8'd2};
    vecs[8] = '{32'h0000F00D, 2'd0, 2'd1, 1'b1, 32'hFFFFF00D, 1'b0, 8'd2};
    vecs[9] = '{32'h12345680, 2'd2, 2'd2, 1'b0, 32'h00000000, 1'b1, 8'd3};

    resetn = 1'b0;
    a_valid = 0; a_clr = 0; a_ordy = 1; c_valid = 0; c_clr = 0;
    d_data = '0; d_off = '0; d_size = '0; d_sign = 0;
    b_valid = 0; b_data = '0; b_off = '0; b_size = '0; b_sign = 0;

    #3;
    chk("rst out_valid", a_ovalid, 0);
    chk("rst in_ready", a_iready, 1);
    chk("rst out_data", a_odata, 0);
    chk("rst err_cnt", a_cnt, 0);
    #9 resetn = 1'b1;
    tick;
    chk("post-rst in_ready", a_iready, 1);
    chk("post-rst out_valid", a_ovalid, 0);

    // Back-to-back vector table with out_ready held high.
    for (int i = 0; i < NV; i++) begin
      d_data = vecs[i].data; d_off = vecs[i].off;
      d_size = vecs[i].size; d_sign = vecs[i].sign;
      a_valid = 1;
      tick;
      chk($sformatf("vec%0d valid", i), a_ovalid, 1);
      chk($sformatf("vec%0d data", i), a_odata, vecs[i].exp_data);
      chk($sformatf("vec%0d adel", i), a_adel, vecs[i].exp_adel);
      chk($sformatf("vec%0d cnt", i), a_cnt, vecs[i].exp_cnt);
    end
    a_valid = 0;
    tick;
    chk("drain valid", a_ovalid, 0);
    chk("drain data hold", a_odata, 32'h00000000);

    // Backpressure: result held while out_ready=0.
    d_data = 32'h12345680; d_off = 0; d_size = 0; d_sign = 0;
    a_valid = 1; a_ordy = 0;
    tick;
    chk("hold first data", a_odata, 32'h00000080);
    d_off = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("hold%0d in_ready", k), a_iready, 0);
      chk($sformatf("hold%0d valid", k), a_ovalid, 1);
      chk($sformatf("hold%0d data", k), a_odata, 32'h00000080);
    end
    a_ordy = 1;
    #1 chk("release in_ready", a_iready, 1);
    tick;
    chk("b2b1 valid", a_ovalid, 1);
    chk("b2b1 data", a_odata, 32'h00000056);
    d_off = 2;
    tick;
    chk("b2b2 valid", a_ovalid, 1);
    chk("b2b2 data", a_odata, 32'h00000034);
    a_valid = 0;
    tick;
    chk("idle valid", a_ovalid, 0);
    chk("idle data hold", a_odata, 32'h00000034);

    // Clear wins over a coincident misaligned acceptance.
    d_off = 1; d_size = 1; a_valid = 1; a_clr = 1;
    tick;
    chk("clr adel", a_adel, 1);
    chk("clr cnt", a_cnt, 0);
    a_valid = 0; a_clr = 0;
    tick;

    // Saturation on the CNT_W=2 instance.
    c_valid = 1;
    for (int k = 0; k < 5; k++) tick;
    chk("sat cnt", c_cnt, 3);
    chk("sat adel", c_adel, 1);
    chk("sat data", c_odata, 0);
    c_clr = 1;
    tick;
    chk("sat clr cnt", c_cnt, 0);
    c_valid = 0; c_clr = 0;
    tick;

    // 64-bit instance.
    b_data = 64'h8000000000000000; b_off = 4; b_size = 2; b_sign = 1; b_valid = 1;
    tick;
    chk("w64 word data", b_odata, 64'hFFFFFFFF80000000);
    chk("w64 word adel", b_adel, 0);
    b_data = 64'h0123456789ABCDEF; b_off = 0; b_size = 3;
    tick;
    chk("w64 dword data", b_odata, 64'h0123456789ABCDEF);
    chk("w64 dword adel", b_adel, 0);
    b_off = 4;
    tick;
    chk("w64 mis adel", b_adel, 1);
    chk("w64 mis data", b_odata, 0);
    chk("w64 mis cnt", b_cnt, 1);
    b_valid = 0;
    tick;

    // Asynchronous reset with a pending result that must be discarded.
    d_data = 32'h12345680; d_off = 1; d_size = 1; a_valid = 1; a_ordy = 0;
    tick;
    chk("pre-rst valid", a_ovalid, 1);
    chk("pre-rst cnt", a_cnt, 1);
    a_valid = 0;
    #2 resetn = 1'b0;
    #1;
    chk("arst valid", a_ovalid, 0);
    chk("arst adel", a_adel, 0);
    chk("arst cnt", a_cnt, 0);
    chk("arst in_ready", a_iready, 1);
    chk("arst b cnt", b_cnt, 0);
    #3 resetn = 1'b1;
    a_ordy = 1;
    tick;
    chk("after-rst valid", a_ovalid, 0);
    chk("after-rst in_ready", a_iready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
